// File: rtl/pc_update.sv
// rtl/pc_update.sv - fetch-stage program counter with run/step/halt gating and cycle counter
module pc_update #(
    parameter int                    N_BITS_DW   = 32,
    parameter int                    N_BITS_JIDX = 26,
    parameter logic [N_BITS_DW-1:0]  RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_start,
    input  logic                   i_step_mode,
    input  logic                   i_step,
    input  logic                   i_stall,
    input  logic                   i_halt_detected,
    input  logic                   i_branch_taken,
    input  logic [N_BITS_DW-1:0]   i_branch_target,
    input  logic                   i_jump,
    input  logic [N_BITS_JIDX-1:0] i_jump_index,
    input  logic [N_BITS_DW-1:0]   i_jump_pc,
    input  logic                   i_jump_reg,
    input  logic [N_BITS_DW-1:0]   i_jump_reg_target,
    output logic [N_BITS_DW-1:0]   o_pc,
    output logic [N_BITS_DW-1:0]   o_pc_plus4,
    output logic                   o_pc_enable,
    output logic                   o_flush_if,
    output logic                   o_halted,
    output logic [N_BITS_DW-1:0]   o_cycle_count
);

    localparam int                   N_SEG   = N_BITS_DW - N_BITS_JIDX - 2;
    localparam logic [N_BITS_DW-1:0] PC_INC  = N_BITS_DW'(4);
    localparam logic [N_BITS_DW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 adv;
    logic                 redirect;
    logic [N_BITS_DW-1:0] pc_r;
    logic [N_BITS_DW-1:0] pc_next;
    logic [N_BITS_DW-1:0] cnt_r;
    logic                 unused_bits;

    // Target low bits are forced to zero, so those input bits are intentionally dropped.
    assign unused_bits = ^{i_branch_target[1:0], i_jump_reg_target[1:0],
                           i_jump_pc[N_BITS_DW-N_SEG-1:0]};

    always_comb begin
        state_next = state;
        adv        = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next = i_step_mode ? STEP : RUN;
                end
            end
            RUN:     adv = 1'b1;
            STEP:    adv = i_step;
            HALTED:  adv = 1'b0;
            default: state_next = IDLE;
        endcase
        if (adv && !i_stall && i_halt_detected) begin
            state_next = HALTED;
        end
    end

    assign o_pc_enable = adv & ~i_stall;
    assign redirect    = i_jump_reg | i_jump | i_branch_taken;
    assign o_flush_if  = o_pc_enable & ~i_halt_detected & redirect;
    assign o_halted    = (state == HALTED);
    assign o_pc        = pc_r;
    assign o_pc_plus4  = pc_r + PC_INC;
    assign o_cycle_count = cnt_r;

    // HALT outranks every redirect; among redirects JR beats J beats branch.
    always_comb begin
        pc_next = pc_r + PC_INC;
        if (i_halt_detected) begin
            pc_next = pc_r;
        end else if (i_jump_reg) begin
            pc_next = {i_jump_reg_target[N_BITS_DW-1:2], 2'b00};
        end else if (i_jump) begin
            pc_next = {i_jump_pc[N_BITS_DW-1 -: N_SEG], i_jump_index, 2'b00};
        end else if (i_branch_taken) begin
            pc_next = {i_branch_target[N_BITS_DW-1:2], 2'b00};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
            pc_r  <= {RESET_PC[N_BITS_DW-1:2], 2'b00};
            cnt_r <= '0;
        end else begin
            state <= state_next;
            if (o_pc_enable) begin
                pc_r <= pc_next;
                if (cnt_r != CNT_MAX) begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - scoreboard bench for pc_update
module tb_pc_update;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        stall;
    logic        halt_detected;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] jump_pc;
    logic        jump_reg;
    logic [31:0] jump_reg_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_enable;
    logic        flush_if;
    logic        halted;
    logic [31:0] cycle_count;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] exp_count;
    logic [31:0] got;

    pc_update dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_start           (start),
        .i_step_mode       (step_mode),
        .i_step            (step),
        .i_stall           (stall),
        .i_halt_detected   (halt_detected),
        .i_branch_taken    (branch_taken),
        .i_branch_target   (branch_target),
        .i_jump            (jump),
        .i_jump_index      (jump_index),
        .i_jump_pc         (jump_pc),
        .i_jump_reg        (jump_reg),
        .i_jump_reg_target (jump_reg_target),
        .o_pc              (pc),
        .o_pc_plus4        (pc_plus4),
        .o_pc_enable       (pc_enable),
        .o_flush_if        (flush_if),
        .o_halted          (halted),
        .o_cycle_count     (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; step_mode = 0; step = 0; stall = 0; halt_detected = 0;
        branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
        jump_pc = 0; jump_reg = 0; jump_reg_target = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        model_pc  = 32'h0;
        exp_count = 32'h0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (cycle_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", cycle_count); end
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL reset_pc_enable got=%b exp=0", pc_enable); end
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", flush_if); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    endtask

    task automatic test_run();
        start = 1; step_mode = 0;
        exp_q.push_back(32'h0);
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL idle_no_adv got=%b exp=0", pc_enable); end
        tick();
        start = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL run_start_pc got=%h exp=%h", pc, got); end
        for (int i = 0; i < 8; i++) begin
            total++; if (pc_enable !== 1'b1) begin bad++; $display("FAIL run_adv[%0d] got=%b exp=1", i, pc_enable); end
            model_pc = model_pc + 32'd4;
            exp_count = exp_count + 1;
            exp_q.push_back(model_pc);
            tick();
            got = exp_q.pop_front();
            total++; if (pc !== got) begin bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, pc, got); end
            if (i == 3) begin
                total++; if (cycle_count !== 32'd4) begin bad++; $display("FAIL run_count4 got=%0d exp=4", cycle_count); end
            end
        end
        total++; if (pc_plus4 !== 32'h24) begin bad++; $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, 32'h24); end
    endtask

    task automatic test_branch_jump();
        // branch at 0x20 -> 0x100
        branch_taken = 1; branch_target = 32'h100;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL branch_flush got=%b exp=1", flush_if); end
        exp_q.push_back(32'h100); exp_count = exp_count + 1;
        tick();
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL branch_pc got=%h exp=%h", pc, got); end
        // misaligned branch target is word-aligned
        branch_target = 32'h43;
        exp_q.push_back(32'h40); exp_count = exp_count + 1;
        tick();
        branch_taken = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL branch_align got=%h exp=%h", pc, got); end
        jump = 1; jump_index = 26'h0000010; jump_pc = 32'h40000044;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL jump_flush got=%b exp=1", flush_if); end
        exp_q.push_back(32'h40000040); exp_count = exp_count + 1;
        tick();
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL jump_pc got=%h exp=%h", pc, got); end
        jump_reg = 1; jump_reg_target = 32'h1237; branch_taken = 1; branch_target = 32'h800;
        exp_q.push_back(32'h1234); exp_count = exp_count + 1;
        tick();
        jump = 0; jump_reg = 0; branch_taken = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL jr_priority got=%h exp=%h", pc, got); end
        model_pc = 32'h1234;
        total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL redirect_count got=%0d exp=%0d", cycle_count, exp_count); end
    endtask

    task automatic test_stall();
        stall = 1; branch_taken = 1; branch_target = 32'h500;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL stall_enable[%0d] got=%b exp=0", i, pc_enable); end
            total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL stall_flush[%0d] got=%b exp=0", i, flush_if); end
            exp_q.push_back(model_pc);
            tick();
            got = exp_q.pop_front();
            total++; if (pc !== got) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, got); end
        end
        total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", cycle_count, exp_count); end
        stall = 0;
        #1;
        total++; if (flush_if !== 1'b1) begin bad++; $display("FAIL stall_release_flush got=%b exp=1", flush_if); end
        exp_q.push_back(32'h500); exp_count = exp_count + 1;
        tick();
        branch_taken = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL stall_release_pc got=%h exp=%h", pc, got); end
    endtask

    task automatic test_wrap();
        jump_reg = 1; jump_reg_target = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC); exp_count = exp_count + 1;
        tick();
        jump_reg = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL wrap_setup got=%h exp=%h", pc, got); end
        exp_q.push_back(32'h0); exp_count = exp_count + 1;
        tick();
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, got); end
        total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", cycle_count, exp_count); end
    endtask

    task automatic test_step();
        clear_inputs();
        do_reset();
        start = 1; step_mode = 1;
        tick();
        start = 0;
        for (int c = 0; c < 10; c++) begin
            step = (c == 3 || c == 7);
            #1;
            total++; if (pc_enable !== step) begin bad++; $display("FAIL step_enable[%0d] got=%b exp=%b", c, pc_enable, step); end
            if (step) begin
                model_pc = model_pc + 32'd4;
                exp_count = exp_count + 1;
            end
            exp_q.push_back(model_pc);
            tick();
            got = exp_q.pop_front();
            total++; if (pc !== got) begin bad++; $display("FAIL step_pc[%0d] got=%h exp=%h", c, pc, got); end
        end
        step = 0;
        total++; if (cycle_count !== 32'd2) begin bad++; $display("FAIL step_count got=%0d exp=2", cycle_count); end
    endtask

    task automatic test_halt();
        clear_inputs();
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 3; i++) begin
            model_pc = model_pc + 32'd4;
            exp_count = exp_count + 1;
            tick();
        end
        halt_detected = 1; jump = 1; jump_index = 26'h3FF; jump_pc = 32'h8000_0000;
        #1;
        total++; if (flush_if !== 1'b0) begin bad++; $display("FAIL halt_flush got=%b exp=0", flush_if); end
        exp_q.push_back(model_pc); exp_count = exp_count + 1;
        tick();
        halt_detected = 0; jump = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL halt_pc got=%h exp=%h", pc, got); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted got=%b exp=1", halted); end
        start = 1;
        #1;
        total++; if (pc_enable !== 1'b0) begin bad++; $display("FAIL halted_enable got=%b exp=0", pc_enable); end
        exp_q.push_back(model_pc);
        tick();
        tick();
        start = 0;
        got = exp_q.pop_front();
        total++; if (pc !== got) begin bad++; $display("FAIL halted_hold got=%h exp=%h", pc, got); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_start_ignored got=%b exp=1", halted); end
        total++; if (cycle_count !== exp_count) begin bad++; $display("FAIL halted_count got=%0d exp=%0d", cycle_count, exp_count); end
        do_reset();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL halt_reset_pc got=%h exp=0", pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset_halted got=%b exp=0", halted); end
        total++; if (cycle_count !== 32'h0) begin bad++; $display("FAIL halt_reset_count got=%0d exp=0", cycle_count); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_run();
        test_branch_jump();
        test_stall();
        test_wrap();
        test_step();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
